hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard-detection and forwarding unit for the in-order pipeline. It sits beside the ID stage. It tracks every in-flight register write in a DEPTH-stage shift-register scoreboard, where each write carries its own result-ready stage. From this it drives the ID stall and the EX operand-forwarding selects. It generalises the fixed two-stage, load-only detector with per-instruction producer latency, configurable depth, flush/hold handling and a stall counter.

## Interface
- `DEPTH`, 3: tracked post-ID stages. Stage 1 is EX and stage DEPTH is WB. Minimum 2.
- `REG_W`, 5: register-address width.
- `SEL_W`, 2: operand-select width. Must satisfy 2^SEL_W ≥ DEPTH.
- `CNT_W`, 16: stall-counter width.

Ports:
- `clk`, in, 1: clock. Rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `Rs_ID`, in, REG_W: source A of the instruction in ID.
- `Rt_ID`, in, REG_W: source B of the instruction in ID.
- `ALU_SRC`, in, 1: 1 = operand B is an immediate, so `Rt_ID` is not a source.
- `issue_valid`, in, 1: ID holds a real instruction.
- `Wr_ID`, in, 1: the ID instruction writes `Rw_ID`.
- `Rw_ID`, in, REG_W: destination of the ID instruction.
- `rdy_ID`, in, SEL_W: stage after which the result becomes forwardable (ALU = 1, load = 2).
- `flush_EX`, in, 1: squash the instructions in EX and ID.
- `hold`, in, 1: global pipeline freeze.
- `Stall_ID`, out, 1: hold ID and insert a bubble into EX.
- `OP_A_SEL`, out, SEL_W: 0 = register file; s = pipeline register after stage s.
- `OP_B_SEL`, out, SEL_W: same encoding as `OP_A_SEL`.
- `stall_count`, out, CNT_W: saturating count of stall cycles.

## Operation
- **Scoreboard entry.** Stage k (1..DEPTH) holds `{v, rw, rdy}`.
- **Ready-stage clamping.** `rdy_ID` of 0 is treated as 1. Values above DEPTH-1 are clamped to DEPTH-1.
- **Match rule.** A source matches stage k when all of the following hold:
  - `v` is set;
  - `rw` equals the source address;
  - k ≤ DEPTH-1.
- **Ignored sources.**
  - Register 0 never matches.
  - The stage-DEPTH entry never matches, because the register file is write-before-read.
  - `Rt_ID` is ignored when `ALU_SRC`=1. In that case `OP_B_SEL`=0.
  - With `issue_valid`=0, both selects are 0 and there is no stall.
- **Priority.** The youngest match (lowest k) wins.
  - If `rdy` ≤ k: SEL = k.
  - Otherwise the source is unready.
  - No match gives SEL = 0.
- **Stall.** `Stall_ID` = issue_valid & (A unready | B unready). While stalling, both selects are 0.
- **Update.** On each rising edge with `hold`=0:
  - stage[k] ← stage[k-1] for k = 2..DEPTH;
  - stage[1] ← `{1, Rw_ID, rdy}` if issue_valid & Wr_ID & `Rw_ID`≠0 & !Stall_ID & !flush_EX;
  - otherwise stage[1] ← bubble.
- **Flush.** `flush_EX`=1 invalidates the stage-1 entry.
  - It takes effect even when `hold`=1; in that case the invalidation is in place with no shift.
  - Older stages are unaffected.
- **Hold.** `hold`=1 without flush freezes all stages and `stall_count`.
- **Stall counter.** `stall_count` increments on each edge where `Stall_ID`=1 & `hold`=0. It saturates at all-ones.

## Timing
- `Stall_ID` and `OP_*_SEL` are combinational from the ID inputs and the registered scoreboard, valid in the same cycle. The datapath registers the selects into ID/EX.
- Scoreboard and counter update on the rising edge of `clk`.
- **Reset.** `rst_n`=0 immediately, asynchronously:
  - clears all `v`;
  - clears `stall_count` to 0.
  
  The result is `Stall_ID`=0 and `OP_A_SEL`=`OP_B_SEL`=0 for any inputs. Reset mid-operation discards all in-flight entries.
- **Stall length.** A dependent instruction stalls for rdy−k cycles, where k is the producer's current stage. One bubble is inserted per stall cycle.
- A producer leaves the scoreboard DEPTH cycles after issue, unless `hold` extends this.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding operates as above.
- `HAZARD_FWD_EN` undefined:
  - both selects are tied to 0;
  - any match in stages 1..DEPTH-1 is unready regardless of `rdy`;
  - consumers stall until the producer reaches stage DEPTH.
  
  Ports are unchanged.

## Test plan
- **Reset.** Preload stage1=`{1,1,1}`, then assert `rst_n`=0 with `Rs_ID`=1 → `Stall_ID`=0, `OP_A_SEL`=0, `stall_count`=0 without a clock edge.
- **ALU back-to-back.** Issue `Rw_ID`=1, `rdy_ID`=1. Next cycle `Rs_ID`=1 → `OP_A_SEL`=1, `Stall_ID`=0. One cycle later, a second reader of reg 1 → `OP_A_SEL`=2.
- **Load-use.** Issue `Rw_ID`=2, `rdy_ID`=2. Next cycle `Rt_ID`=2, `ALU_SRC`=0 → `Stall_ID`=1 for exactly 1 cycle, then `OP_B_SEL`=2, `stall_count`=1. Repeat with `ALU_SRC`=1 → no stall, `OP_B_SEL`=0.
- **Youngest match.** Stage1 and stage2 both hold `rw`=3 with `rdy`=1. `Rs_ID`=`Rt_ID`=3 → `OP_A_SEL`=`OP_B_SEL`=1. `Rw_ID`=0 writes never cause a hazard.
- **Flush and hold.**
  - Load to reg 4 in stage1, then `flush_EX`=1 → next cycle `Rs_ID`=4 gives `OP_A_SEL`=0, no stall.
  - With stage1=`{1,5,2}` and `hold`=1 for 3 cycles → `Stall_ID` stays 1 and `stall_count` stays frozen.
- **`HAZARD_FWD_EN` undefined, DEPTH=3.** ALU producer to reg 6, dependent next → `Stall_ID`=1 for 2 cycles, then `OP_A_SEL`=0, `stall_count`=2.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard-detection / forwarding scoreboard beside ID: tracks in-flight writes per stage and drives stall + EX operand selects.
// Define HAZARD_FWD_EN to enable forwarding; without it every in-flight match stalls until the producer reaches WB.
module hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int REG_W = 5,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    input  logic             ALU_SRC,
    input  logic             issue_valid,
    input  logic             Wr_ID,
    input  logic [REG_W-1:0] Rw_ID,
    input  logic [SEL_W-1:0] rdy_ID,
    input  logic             flush_EX,
    input  logic             hold,
    output logic             Stall_ID,
    output logic [SEL_W-1:0] OP_A_SEL,
    output logic [SEL_W-1:0] OP_B_SEL,
    output logic [CNT_W-1:0] stall_count
);

    logic             stage_v   [1:DEPTH];
    logic [REG_W-1:0] stage_rw  [1:DEPTH];
    logic [SEL_W-1:0] stage_rdy [1:DEPTH];

    logic [SEL_W-1:0] rdy_clamped;
    logic             a_unrdy;
    logic             b_unrdy;
    logic             issue_write;

    always_comb begin
        if (rdy_ID == '0)
            rdy_clamped = SEL_W'(1);
        else if (int'(rdy_ID) > DEPTH - 1)
            rdy_clamped = SEL_W'(DEPTH - 1);
        else
            rdy_clamped = rdy_ID;
    end

`ifdef HAZARD_FWD_EN
    logic [SEL_W-1:0] a_sel;
    logic [SEL_W-1:0] b_sel;

    // Scan oldest to youngest so the lowest matching stage overwrites older results.
    always_comb begin
        a_unrdy = 1'b0;
        b_unrdy = 1'b0;
        a_sel   = '0;
        b_sel   = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (stage_v[k] && stage_rw[k] == Rs_ID && Rs_ID != '0) begin
                a_unrdy = int'(stage_rdy[k]) > k;
                a_sel   = (int'(stage_rdy[k]) > k) ? '0 : SEL_W'(k);
            end
            if (!ALU_SRC && stage_v[k] && stage_rw[k] == Rt_ID && Rt_ID != '0) begin
                b_unrdy = int'(stage_rdy[k]) > k;
                b_sel   = (int'(stage_rdy[k]) > k) ? '0 : SEL_W'(k);
            end
        end
    end

    assign OP_A_SEL = (issue_valid && !Stall_ID) ? a_sel : '0;
    assign OP_B_SEL = (issue_valid && !Stall_ID) ? b_sel : '0;
`else
    always_comb begin
        a_unrdy = 1'b0;
        b_unrdy = 1'b0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (stage_v[k] && stage_rw[k] == Rs_ID && Rs_ID != '0)
                a_unrdy = 1'b1;
            if (!ALU_SRC && stage_v[k] && stage_rw[k] == Rt_ID && Rt_ID != '0)
                b_unrdy = 1'b1;
        end
    end

    assign OP_A_SEL = '0;
    assign OP_B_SEL = '0;
`endif

    assign Stall_ID    = issue_valid & (a_unrdy | b_unrdy);
    assign issue_write = issue_valid & Wr_ID & (Rw_ID != '0) & ~Stall_ID & ~flush_EX;

    // A flushed EX entry must not survive into MEM, and under hold it is killed in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                stage_v[k]   <= 1'b0;
                stage_rw[k]  <= '0;
                stage_rdy[k] <= '0;
            end
            stall_count <= '0;
        end else if (!hold) begin
            for (int k = DEPTH; k >= 3; k--) begin
                stage_v[k]   <= stage_v[k-1];
                stage_rw[k]  <= stage_rw[k-1];
                stage_rdy[k] <= stage_rdy[k-1];
            end
            stage_v[2]   <= stage_v[1] & ~flush_EX;
            stage_rw[2]  <= stage_rw[1];
            stage_rdy[2] <= stage_rdy[1];
            stage_v[1]   <= issue_write;
            stage_rw[1]  <= Rw_ID;
            stage_rdy[1] <= rdy_clamped;
            if (Stall_ID && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end else if (flush_EX) begin
            stage_v[1] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=3); expectations follow HAZARD_FWD_EN when it is defined.
module tb_hazard_scoreboard;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs_ID, Rt_ID, Rw_ID;
    logic        ALU_SRC, issue_valid, Wr_ID, flush_EX, hold;
    logic [1:0]  rdy_ID;
    logic        Stall_ID;
    logic [1:0]  OP_A_SEL, OP_B_SEL;
    logic [15:0] stall_count;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [4:0]  rs, rt;
        logic        alu_src, issue, wr;
        logic [4:0]  rw;
        logic [1:0]  rdy;
        logic        flush, hold;
        logic        exp_stall;
        logic [1:0]  exp_a, exp_b;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    hazard_scoreboard #(.DEPTH(3), .REG_W(5), .SEL_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .ALU_SRC(ALU_SRC),
        .issue_valid(issue_valid), .Wr_ID(Wr_ID), .Rw_ID(Rw_ID), .rdy_ID(rdy_ID),
        .flush_EX(flush_EX), .hold(hold), .Stall_ID(Stall_ID), .OP_A_SEL(OP_A_SEL),
        .OP_B_SEL(OP_B_SEL), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int rs, int rt, int alu, int iss, int wr, int rw, int rdy,
                                int fl, int hd, int st, int a, int b, int cnt);
        vec_t v;
        v.rs = 5'(rs);       v.rt = 5'(rt);     v.alu_src = 1'(alu);
        v.issue = 1'(iss);   v.wr = 1'(wr);     v.rw = 5'(rw);
        v.rdy = 2'(rdy);     v.flush = 1'(fl);  v.hold = 1'(hd);
        v.exp_stall = 1'(st); v.exp_a = 2'(a);  v.exp_b = 2'(b);
        v.exp_cnt = 16'(cnt);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        Rs_ID = v.rs;  Rt_ID = v.rt;  ALU_SRC = v.alu_src;  issue_valid = v.issue;
        Wr_ID = v.wr;  Rw_ID = v.rw;  rdy_ID = v.rdy;       flush_EX = v.flush;
        hold = v.hold;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef HAZARD_FWD_EN
        vecs.push_back(mk(0,0,1,1,1,1,1,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0,0,0,0, 0,1,0,0));
        vecs.push_back(mk(1,0,0,1,0,0,0,0,0, 0,2,0,0));
        vecs.push_back(mk(1,0,0,1,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,1,1,1,2,2,0,0, 0,0,0,0));
        vecs.push_back(mk(0,2,0,1,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(0,2,0,1,0,0,0,0,0, 0,0,2,1));
        vecs.push_back(mk(0,0,1,1,1,2,2,0,0, 0,0,0,1));
        vecs.push_back(mk(0,2,1,1,0,0,0,0,0, 0,0,0,1));
        vecs.push_back(mk(0,0,1,1,1,3,1,0,0, 0,0,0,1));
        vecs.push_back(mk(3,3,0,1,1,3,1,0,0, 0,1,1,1));
        vecs.push_back(mk(3,3,0,1,1,0,2,0,0, 0,1,1,1));
        vecs.push_back(mk(0,0,0,1,0,0,0,0,0, 0,0,0,1));
        vecs.push_back(mk(0,0,1,1,1,4,2,0,0, 0,0,0,1));
        vecs.push_back(mk(0,0,1,0,0,0,0,1,0, 0,0,0,1));
        vecs.push_back(mk(4,0,1,1,0,0,0,0,0, 0,0,0,1));
        vecs.push_back(mk(0,0,1,1,1,5,2,0,0, 0,0,0,1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(5,0,1,1,0,0,0,0,1, 1,0,0,1));
        vecs.push_back(mk(5,0,1,1,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(5,0,1,1,0,0,0,0,0, 0,2,0,2));
        vecs.push_back(mk(0,0,1,1,1,7,2,0,0, 0,0,0,2));
        vecs.push_back(mk(0,0,1,0,0,0,0,1,1, 0,0,0,2));
        vecs.push_back(mk(7,0,1,1,0,0,0,0,0, 0,0,0,2));
`else
        vecs.push_back(mk(0,0,1,1,1,1,1,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(1,0,0,1,0,0,0,0,0, 0,0,0,2));
        vecs.push_back(mk(0,0,1,1,1,2,2,0,0, 0,0,0,2));
        vecs.push_back(mk(0,2,0,1,0,0,0,0,0, 1,0,0,2));
        vecs.push_back(mk(0,2,0,1,0,0,0,0,0, 1,0,0,3));
        vecs.push_back(mk(0,2,0,1,0,0,0,0,0, 0,0,0,4));
        vecs.push_back(mk(0,0,1,1,1,2,2,0,0, 0,0,0,4));
        vecs.push_back(mk(0,2,1,1,0,0,0,0,0, 0,0,0,4));
        vecs.push_back(mk(0,0,1,1,1,3,1,0,0, 0,0,0,4));
        vecs.push_back(mk(3,3,0,1,1,0,2,0,0, 1,0,0,4));
        vecs.push_back(mk(3,3,0,1,1,0,2,0,0, 1,0,0,5));
        vecs.push_back(mk(3,3,0,1,1,0,2,0,0, 0,0,0,6));
        vecs.push_back(mk(0,0,1,1,1,4,2,0,0, 0,0,0,6));
        vecs.push_back(mk(0,0,1,0,0,0,0,1,0, 0,0,0,6));
        vecs.push_back(mk(4,0,1,1,0,0,0,0,0, 0,0,0,6));
        vecs.push_back(mk(0,0,1,1,1,5,2,0,0, 0,0,0,6));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(5,0,1,1,0,0,0,0,1, 1,0,0,6));
        vecs.push_back(mk(5,0,1,1,0,0,0,0,0, 1,0,0,6));
        vecs.push_back(mk(5,0,1,1,0,0,0,0,0, 1,0,0,7));
        vecs.push_back(mk(5,0,1,1,0,0,0,0,0, 0,0,0,8));
        vecs.push_back(mk(0,0,1,1,1,7,2,0,0, 0,0,0,8));
        vecs.push_back(mk(0,0,1,0,0,0,0,1,1, 0,0,0,8));
        vecs.push_back(mk(7,0,1,1,0,0,0,0,0, 0,0,0,8));
`endif

        rst_n = 1'b0;
        applyStimulus(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Preload stage1 with a write to r1, then pull reset mid-cycle.
        @(negedge clk);
        applyStimulus(mk(0,0,1,1,1,1,1,0,0, 0,0,0,0));
        @(negedge clk);
        applyStimulus(mk(1,0,0,1,0,0,0,0,0, 0,0,0,0));
        #1;
        checkOutput("preload stall", 32'(Stall_ID), FWD ? 32'd0 : 32'd1);
        checkOutput("preload opa", 32'(OP_A_SEL), FWD ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        checkOutput("preload2 cnt", 32'(stall_count), FWD ? 32'd0 : 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset stall", 32'(Stall_ID), 32'd0);
        checkOutput("reset opa", 32'(OP_A_SEL), 32'd0);
        checkOutput("reset cnt", 32'(stall_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post-reset stall", 32'(Stall_ID), 32'd0);
        checkOutput("post-reset opa", 32'(OP_A_SEL), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d stall", i), 32'(Stall_ID), 32'(vecs[i].exp_stall));
            checkOutput($sformatf("row%0d opa", i), 32'(OP_A_SEL), 32'(vecs[i].exp_a));
            checkOutput($sformatf("row%0d opb", i), 32'(OP_B_SEL), 32'(vecs[i].exp_b));
            checkOutput($sformatf("row%0d cnt", i), 32'(stall_count), 32'(vecs[i].exp_cnt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
